// File: rtl/keypad_pkg.sv
// Shared key codes, scanner state encoding and the row/column to key-code map.
package keypad_pkg;

    localparam logic [3:0] ADD          = 4'b1100;
    localparam logic [3:0] SUB          = 4'b1011;
    localparam logic [3:0] IGUAL        = 4'b1101;
    localparam logic [3:0] SAVE         = 4'b1111;
    localparam logic [3:0] RECOVERY     = 4'b1110;
    localparam logic [3:0] KEY_RESERVED = 4'b1010;

    typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HOLD, RELEASE} scanState_t;

    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = ADD;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = SUB;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = IGUAL;
            4'hC: code = SAVE;
            4'hD: code = 4'd0;
            4'hE: code = RECOVERY;
            default: code = KEY_RESERVED;
        endcase
        return code;
    endfunction

    // True only when exactly one active-low column is asserted.
    function automatic logic oneLow(input logic [3:0] cs);
        return (cs == 4'b1110) || (cs == 4'b1101) || (cs == 4'b1011) || (cs == 4'b0111);
    endfunction

    function automatic logic [1:0] colOf(input logic [3:0] cs);
        logic [1:0] col;
        case (cs)
            4'b1101: col = 2'd1;
            4'b1011: col = 2'd2;
            4'b0111: col = 2'd3;
            default: col = 2'd0;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the key-code/ready handshake towards the operation FSM.
interface keypad_scanner_if;
    logic [3:0] cols_n;
    logic [3:0] rows_n;
    logic [3:0] tecla;
    logic       ready;
    logic       key_held;

    modport master (input cols_n, output rows_n, tecla, ready, key_held);
    modport slave  (output cols_n, input rows_n, tecla, ready, key_held);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser; resets to all-ones so idle active-low inputs read as released.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, column debounce, one ready strobe per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000
) (
    input  logic clk,
    input  logic reset,
    keypad_scanner_if.master kp
);
    localparam int MAXC = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW   = $clog2(MAXC + 1);

    scanState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext, cntInc;
    logic [1:0]    rowIdx, rowNext, colIdx, colNext;
    logic [3:0]    latched, latchedNext, teclaQ, teclaNext, cs;

    sync_2ff #(.WIDTH(4)) uSync (.clk(clk), .reset(reset), .d(kp.cols_n), .q(cs));

    assign cntInc = (cnt == CW'(MAXC)) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN;
            cnt     <= '0;
            rowIdx  <= 2'd0;
            colIdx  <= 2'd0;
            latched <= 4'hF;
            teclaQ  <= 4'h0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            rowIdx  <= rowNext;
            colIdx  <= colNext;
            latched <= latchedNext;
            teclaQ  <= teclaNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        rowNext     = rowIdx;
        colNext     = colIdx;
        latchedNext = latched;
        teclaNext   = teclaQ;
        case (state)
            SCAN: begin
                if (cnt == CW'(SCAN_DIV - 1)) begin
                    cntNext = '0;
                    if (oneLow(cs)) begin
                        latchedNext = cs;
                        colNext     = colOf(cs);
                        stateNext   = DEBOUNCE;
                    end else begin
                        rowNext = rowIdx + 2'd1;
                    end
                end else begin
                    cntNext = cntInc;
                end
            end
            DEBOUNCE: begin
                if (cs != latched) begin
                    cntNext   = '0;
                    rowNext   = rowIdx + 2'd1;
                    stateNext = SCAN;
                end else if (cnt == CW'(DEBOUNCE_CNT)) begin
                    // Code is loaded on entry so it is valid in the ready cycle.
                    cntNext   = '0;
                    teclaNext = map_key(rowIdx, colIdx);
                    stateNext = EMIT;
                end else begin
                    cntNext = cntInc;
                end
            end
            EMIT: begin
                cntNext   = '0;
                stateNext = HOLD;
            end
            HOLD: begin
                cntNext = '0;
                if (cs == 4'b1111) stateNext = RELEASE;
            end
            RELEASE: begin
                if (cs != 4'b1111) begin
                    cntNext   = '0;
                    stateNext = HOLD;
                end else if (cnt == CW'(DEBOUNCE_CNT)) begin
                    cntNext   = '0;
                    rowNext   = rowIdx + 2'd1;
                    stateNext = SCAN;
                end else begin
                    cntNext = cntInc;
                end
            end
            default: stateNext = SCAN;
        endcase
    end

    assign kp.rows_n   = ~(4'b0001 << rowIdx);
    assign kp.tecla    = teclaQ;
    assign kp.ready    = (state == EMIT);
    assign kp.key_held = (state == EMIT) || (state == HOLD) || (state == RELEASE);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 matrix keypad and produces the 4-bit key code plus ready strobe consumed by the calculator operation FSM.
- Scans rows, synchronises and debounces columns, and encodes exactly one key per physical press.
- Emits a one-clock ready pulse per debounced press and none for holds or releases.

Parameters:
- SCAN_DIV, 16, clocks each row is driven before columns are sampled (min 4).
- DEBOUNCE_CNT, 1000, consecutive stable clocks required for press and for release acceptance (min 2).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  reset, synchronous, active-high.
- cols_n  in  4  keypad columns, active-low, externally pulled up, asynchronous.
- rows_n  out  4  row drive, one-hot active-low.
- tecla  out  4  key code of last accepted press.
- ready  out  1  one-clock strobe: tecla is valid and new.
- key_held  out  1  high from press acceptance until release is debounced.

Behaviour:
- Reset values:
  - rows_n=4'b1110 (row0), tecla=0, ready=0, key_held=0.
  - State SCAN; row index 0; counters 0.
  - The synchroniser flops reset to 4'b1111.
- cols_n passes through a 2-flop synchroniser; all decisions use the synchronised value cs.
- Key map (row, col -> code):
  - r0: 1,2,3,ADD(1100)
  - r1: 4,5,6,SUB(1011)
  - r2: 7,8,9,IGUAL(1101)
  - r3: SAVE(1111),0,RECOVERY(1110),reserved(1010)
  - Digits are their binary value.
- State SCAN:
  - Drive the current row for SCAN_DIV clocks.
  - On the last dwell clock, evaluate cs:
    - Exactly one bit low: latch row and col, then go to DEBOUNCE. The row is not advanced.
    - All high, or two or more bits low: advance to the next row, wrapping 3->0.
- State DEBOUNCE:
  - The counter increments each clock that cs equals the latched pattern.
  - Any mismatch clears the counter and returns to SCAN with the row advanced.
  - When the counter reaches DEBOUNCE_CNT, go to EMIT.
- State EMIT (exactly 1 clock):
  - tecla is registered from the key map.
  - ready=1 in the same cycle; tecla is already valid in that cycle.
  - key_held=1.
  - Go to HOLD.
- Press-to-ready latency: DEBOUNCE_CNT+1 clocks after leaving SCAN, plus 2 synchroniser clocks.
- State HOLD:
  - The row stays driven and ready=0.
  - Leave when cs==4'b1111, going to RELEASE. Extra keys pressed while holding are ignored.
- State RELEASE:
  - Count consecutive all-high clocks; any low bit clears the counter and returns to HOLD.
  - When the count reaches DEBOUNCE_CNT: key_held=0, advance the row, return to SCAN.
- Output holding:
  - tecla holds its last value outside EMIT.
  - ready is never high for more than one consecutive clock.
  - Only one ready pulse is issued per press, regardless of hold duration or bounce.
- Reset:
  - Reset asserted in any state returns everything to the reset values on the next edge.
  - A press in progress is discarded with no ready.
- Counter width: $clog2(max(SCAN_DIV,DEBOUNCE_CNT)+1). Counters saturate and never wrap.
- rows_n is always one-hot-low; it never has all rows driven or none driven.

Decomposition:
- Package keypad_pkg holds:
  - Key-code constants ADD, SUB, IGUAL, SAVE, RECOVERY, shared with operation.
  - KEY_RESERVED=4'b1010.
  - The state enum {SCAN, DEBOUNCE, EMIT, HOLD, RELEASE}.
  - A pure function map_key(row, col) returning the 4-bit code.
- One sub-module, sync_2ff: a parameterised-width 2-flop synchroniser with synchronous reset to all-ones.

Test Plan:
- Basic press (SCAN_DIV=4, DEBOUNCE_CNT=8):
  - Stimulus: reset, then cols_n=4'b1101 while rows_n=4'b1101 (row1, col1).
  - Response: exactly one ready pulse with tecla=4'b0101, within DEBOUNCE_CNT+SCAN_DIV+3 clocks.
- Bounce rejection:
  - Stimulus: toggle the col0 press on row2 every 3 clocks for 40 clocks, then hold it stable.
  - Response: no ready during toggling; one ready with tecla=4'b0111 after stable debounce.
- Long hold:
  - Stimulus: hold the row0/col3 key for 200 clocks, then release.
  - Response: one ready with tecla=4'b1100; key_held high throughout; key_held low DEBOUNCE_CNT clocks after release.
- Multi-key:
  - Stimulus: two columns low on the same row.
  - Response: no ready; rows keep cycling.
  - Stimulus: a second key on another row pressed while the first is held.
  - Response: no additional ready.
- Reserved and special keys:
  - Stimulus: press row3 col0, col2, col3 in sequence.
  - Response: tecla 1111, 1110, 1010 respectively, one ready each.
- Reset mid-operation:
  - Stimulus: assert reset during DEBOUNCE, and separately during HOLD.
  - Response: next clock rows_n=4'b1110, tecla=0, ready=0, key_held=0; no ready is emitted for the aborted press.
